// File: rtl/determinante_3x3_seq.sv
// -----------------------------------------------------------------------------
// determinante_3x3_seq
//
// Sequential 3x3 signed determinant engine using cofactor expansion along
// row 0. The three 2x2 minors are presented one per cycle on minor_2x2 to
// an external combinational 2x2 determinant stage. Each returned det_2x2 is
// weighted by the matching row-0 element and cofactor sign, then accumulated.
// One shared 2x2 stage serves all three minors.
//
// Optional feature macro: DET3_SINGULAR_FLAG_EN
//   When defined, adds output 'singular', registered together with det at
//   completion, high iff the final determinant is zero.
//
// Ports:
//   clk         in   1       clock, rising edge
//   rst         in   1       asynchronous active-high reset
//   start       in   1       request, sampled only in IDLE
//   matriz_3x3  in   9*EW    row-major signed elements, m00 in the MSBs
//   minor_2x2   out  4*EW    registered minor {a,b,c,d} to the 2x2 stage
//   det_2x2     in   DET_W   signed a*d-b*c from the 2x2 stage
//   busy        out  1       high while a minor is being evaluated
//   done        out  1       one-cycle pulse when det is updated
//   det         out  DET_W   signed 3x3 determinant, held until next done
//   singular    out  1       (DET3_SINGULAR_FLAG_EN only) det == 0
// -----------------------------------------------------------------------------
module determinante_3x3_seq #(
   parameter int ELEM_W = 8,
   parameter int DET_W  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [9*ELEM_W-1:0]   matriz_3x3,
   output logic [4*ELEM_W-1:0]   minor_2x2,
   input  logic [DET_W-1:0]      det_2x2,
   output logic                  busy,
   output logic                  done,
   output logic [DET_W-1:0]      det
`ifdef DET3_SINGULAR_FLAG_EN
   ,
   output logic                  singular
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      M0   = 2'd1,
      M1   = 2'd2,
      M2   = 2'd3
   } state_t;

   state_t                   state;
   logic [9*ELEM_W-1:0]      mat_reg;
   logic signed [DET_W-1:0]  acc;

   // Unpacked view of the latched matrix: elem[0]=m00 ... elem[8]=m22.
   logic [ELEM_W-1:0]        elem [9];
   // Row-0 elements sign-extended to the accumulator width.
   logic signed [DET_W-1:0]  row0_ext [3];

   genvar gi;
   generate
      for (gi = 0; gi < 9; gi++) begin : g_unpack
         assign elem[gi] = mat_reg[(8-gi)*ELEM_W +: ELEM_W];
      end
      for (gi = 0; gi < 3; gi++) begin : g_row0
         assign row0_ext[gi] = {{(DET_W-ELEM_W){elem[gi][ELEM_W-1]}}, elem[gi]};
      end
   endgenerate

   // Weight for the minor currently on minor_2x2 (its row-0 element).
   logic signed [DET_W-1:0]  coef;
   logic signed [DET_W-1:0]  prod;
   logic signed [DET_W-1:0]  det_final;

   always_comb begin
      coef = row0_ext[2];
      case (state)
         M0:      coef = row0_ext[0];
         M1:      coef = row0_ext[1];
         default: coef = row0_ext[2];
      endcase
      // Two's complement wrap at DET_W; magnitudes stay far below 2^(DET_W-1).
      prod      = coef * $signed(det_2x2);
      det_final = acc + prod;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mat_reg   <= '0;
         minor_2x2 <= '0;
         acc       <= '0;
         det       <= '0;
         done      <= 1'b0;
`ifdef DET3_SINGULAR_FLAG_EN
         singular  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mat_reg   <= matriz_3x3;
                  // First minor comes straight from the input: {m11,m12,m21,m22}.
                  minor_2x2 <= {matriz_3x3[3*ELEM_W +: 2*ELEM_W],
                                matriz_3x3[0 +: 2*ELEM_W]};
                  acc       <= '0;
                  state     <= M0;
               end
            end
            M0: begin
               acc       <= prod;
               minor_2x2 <= {elem[3], elem[5], elem[6], elem[8]};
               state     <= M1;
            end
            M1: begin
               // Middle cofactor carries a negative sign.
               acc       <= acc - prod;
               minor_2x2 <= {elem[3], elem[4], elem[6], elem[7]};
               state     <= M2;
            end
            M2: begin
               det       <= det_final;
               done      <= 1'b1;
`ifdef DET3_SINGULAR_FLAG_EN
               singular  <= (det_final == '0);
`endif
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_determinante_3x3_seq.sv
// -----------------------------------------------------------------------------
// tb_determinante_3x3_seq
//
// Self-checking bench for determinante_3x3_seq. A behavioural a*d-b*c model
// plays the external 2x2 stage; expected determinants come from the full
// cofactor formula evaluated with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_determinante_3x3_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [71:0] matriz_3x3;
   logic [31:0] minor_2x2;
   logic [31:0] det_2x2;
   logic        busy;
   logic        done;
   logic [31:0] det;
`ifdef DET3_SINGULAR_FLAG_EN
   logic        singular;
`endif

   int n_vec;
   int n_bad;

   determinante_3x3_seq #(.ELEM_W(8), .DET_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .matriz_3x3 (matriz_3x3),
      .minor_2x2  (minor_2x2),
      .det_2x2    (det_2x2),
      .busy       (busy),
      .done       (done),
      .det        (det)
`ifdef DET3_SINGULAR_FLAG_EN
      ,
      .singular   (singular)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural signed 2x2 determinant stage.
   always_comb begin
      int a, b, c, d;
      a = int'($signed(minor_2x2[31:24]));
      b = int'($signed(minor_2x2[23:16]));
      c = int'($signed(minor_2x2[15:8]));
      d = int'($signed(minor_2x2[7:0]));
      det_2x2 = 32'(a * d - b * c);
   end

   function automatic logic [71:0] pack9(input int m[9]);
      logic [71:0] r;
      for (int i = 0; i < 9; i++) r[(8-i)*8 +: 8] = m[i][7:0];
      return r;
   endfunction

   function automatic logic [31:0] pk4(input int a, input int b, input int c, input int d);
      return {a[7:0], b[7:0], c[7:0], d[7:0]};
   endfunction

   function automatic int ref_det(input int m[9]);
      return m[0] * (m[4]*m[8] - m[5]*m[7])
           - m[1] * (m[3]*m[8] - m[5]*m[6])
           + m[2] * (m[3]*m[7] - m[4]*m[6]);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: pulse start, follow the minor sequence and
   // latency, then check result and the done pulse width.
   task automatic apply_matrix(input string tag, input int m[9]);
      logic [31:0] exp_min [3];
      logic [31:0] exp_det;
      exp_min[0] = pk4(m[4], m[5], m[7], m[8]);
      exp_min[1] = pk4(m[3], m[5], m[6], m[8]);
      exp_min[2] = pk4(m[3], m[4], m[6], m[7]);
      exp_det    = 32'(ref_det(m));
      matriz_3x3 = pack9(m);
      start      = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         start = 1'b0;
         n_vec++;
         if (minor_2x2 !== exp_min[k] || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s minor%0d: got minor=%h busy=%b done=%b, want minor=%h busy=1 done=0",
                     tag, k, minor_2x2, busy, done, exp_min[k]);
         end
      end
      step();
      n_vec++;
      if (done !== 1'b1 || det !== exp_det || busy !== 1'b0 || minor_2x2 !== exp_min[2]) begin
         n_bad++;
         $display("FAIL %s result: got done=%b det=%h busy=%b minor=%h, want done=1 det=%h busy=0 minor=%h",
                  tag, done, det, busy, minor_2x2, exp_det, exp_min[2]);
      end
`ifdef DET3_SINGULAR_FLAG_EN
      n_vec++;
      if (singular !== (exp_det == 32'd0)) begin
         n_bad++;
         $display("FAIL %s singular: got %b, want %b", tag, singular, (exp_det == 32'd0));
      end
`endif
      step();
      n_vec++;
      if (done !== 1'b0 || det !== exp_det) begin
         n_bad++;
         $display("FAIL %s hold: got done=%b det=%h, want done=0 det=%h", tag, done, det, exp_det);
      end
      $display("txn %-10s det=%0d (0x%h)", tag, $signed(det), det);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      matriz_3x3 = '0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || det !== 32'd0 || minor_2x2 !== 32'd0) begin
         n_bad++;
         $display("FAIL reset: got busy=%b done=%b det=%h minor=%h, want all 0", busy, done, det, minor_2x2);
      end
`ifdef DET3_SINGULAR_FLAG_EN
      n_vec++;
      if (singular !== 1'b0) begin
         n_bad++;
         $display("FAIL reset singular: got %b, want 0", singular);
      end
`endif
      rst = 1'b0;
      step();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL idle: got busy=%b done=%b, want 0 0", busy, done);
      end
      $display("txn reset      checked");
   endtask

   task automatic test_directed();
      int m[9];
      m = '{1, 0, 0, 0, 1, 0, 0, 0, 1};             apply_matrix("identity", m);
      m = '{1, 2, 3, 0, 1, 4, 5, 6, 0};             apply_matrix("mat_a", m);
      m = '{1, 2, 3, 4, 5, 6, 7, 8, 9};             apply_matrix("singular", m);
      m = '{-128, 0, 0, 0, -128, 0, 0, 0, -128};    apply_matrix("diag_neg", m);
      m = '{2, 0, 0, 0, 3, 0, 0, 0, 4};             apply_matrix("diag_pos", m);
      m = '{127, -128, 127, -128, 127, -128, 127, -128, -128};
      apply_matrix("extremes", m);
   endtask

   task automatic test_random();
      int m[9];
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < 9; i++) m[i] = int'($urandom_range(0, 255)) - 128;
         apply_matrix("random", m);
      end
   endtask

   // start held for 10 edges: accepted at edges 0, 4, 8; done after 3, 7, 11.
   task automatic test_back_to_back();
      int m[9];
      logic [31:0] exp_det;
      for (int i = 0; i < 9; i++) m[i] = int'($urandom_range(0, 255)) - 128;
      exp_det    = 32'(ref_det(m));
      matriz_3x3 = pack9(m);
      start      = 1'b1;
      for (int k = 0; k < 13; k++) begin
         step();
         if (k == 9) start = 1'b0;
         n_vec++;
         if (done !== (k % 4 == 3 && k < 12)) begin
            n_bad++;
            $display("FAIL b2b done cycle %0d: got %b, want %b", k, done, (k % 4 == 3 && k < 12));
         end
         if (done === 1'b1) begin
            n_vec++;
            if (det !== exp_det) begin
               n_bad++;
               $display("FAIL b2b det cycle %0d: got %h, want %h", k, det, exp_det);
            end
         end
      end
      $display("txn back2back  det=%0d", $signed(exp_det));
   endtask

   // A second start in M1 with a different matrix must be ignored.
   task automatic test_ignore_start();
      int a[9];
      int b[9];
      logic [31:0] exp_det;
      a = '{1, 2, 3, 0, 1, 4, 5, 6, 0};
      b = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
      exp_det    = 32'(ref_det(a));
      matriz_3x3 = pack9(a);
      start      = 1'b1;
      step();                      // now M0
      start      = 1'b0;
      step();                      // now M1
      matriz_3x3 = pack9(b);
      start      = 1'b1;
      step();                      // now M2
      start      = 1'b0;
      step();                      // done cycle
      n_vec++;
      if (done !== 1'b1 || det !== exp_det) begin
         n_bad++;
         $display("FAIL ignore result: got done=%b det=%h, want done=1 det=%h", done, det, exp_det);
      end
      step();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL ignore queued: got busy=%b done=%b, want 0 0", busy, done);
      end
      $display("txn ignore     det=%0d", $signed(det));
   endtask

   task automatic test_async_reset();
      int m[9];
      m = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
      matriz_3x3 = pack9(m);
      start      = 1'b1;
      step();                      // M0
      start      = 1'b0;
      step();                      // M1
      #3;
      rst = 1'b1;
      #1;
      n_vec++;
      if (busy !== 1'b0 || det !== 32'd0 || minor_2x2 !== 32'd0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL async rst: got busy=%b det=%h minor=%h done=%b, want all 0",
                  busy, det, minor_2x2, done);
      end
      #2;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         n_vec++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post-rst cycle %0d: got done=%b busy=%b, want 0 0", k, done, busy);
         end
      end
      $display("txn async_rst  aborted");
      apply_matrix("after_rst", m);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_ignore_start();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
